// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared constants, FSM state type and frame builder for the
// bus-to-SPI SRAM bridge.
`timescale 1ns/1ps
package spi_mem_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One SPI transaction: opcode, address high, address low, data byte.
  // Reads send a zero data byte while the SRAM answers on MISO.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        is_write,
    input logic [15:0] addr,
    input logic [7:0]  wdata
  );
    return {(is_write ? SPI_OP_WRITE : SPI_OP_READ), addr,
            (is_write ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_mem_if.sv
// spi_mem_if: CPU-side byte bus between the bus logic (master) and the
// SPI memory bridge (slave).
//
// Handshake: the master raises bus_read or bus_write with a stable address
// (and write data) and holds it until bus_done is seen high for one cycle;
// it drops the strobe on the clock edge that ends the bus_done cycle.
// bus_rdata is valid in the bus_done cycle of a read and holds until the
// next read completes. A strobe still high in the cycle after bus_done is a
// new request.
`timescale 1ns/1ps
interface spi_mem_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        bus_done;

  modport master (
    output bus_address_in, bus_wdata, bus_read, bus_write,
    input  bus_rdata, bus_done
  );

  modport slave (
    input  bus_address_in, bus_wdata, bus_read, bus_write,
    output bus_rdata, bus_done
  );
endinterface

// File: rtl/spi_mem_shifter.sv
// spi_mem_shifter: SPI mode-0 frame engine. Divides clk down to spi_clk,
// shifts a 32-bit frame out MSB first and collects MISO. frame_done is a
// combinational flag that is high in the cycle whose closing edge ends the
// frame (the final spi_clk falling edge), so the caller can complete on
// that same edge.
`timescale 1ns/1ps
module spi_mem_shifter
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  frame_done,
  output logic [7:0]            rx_byte,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic                  active_q;
  logic [7:0]            div_q;
  logic [4:0]            bit_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [7:0]            rx_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  tick;

  assign tick       = active_q && (div_q == DIV_LAST);
  assign frame_done = tick && sclk_q && (bit_q == LAST_BIT);

  assign rx_byte  = rx_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

  // Divider, bit counter and shift registers; spi_clk toggles every CLK_DIV
  // cycles starting low, MOSI moves on falling edges, MISO sampled on rising.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else if (!active_q) begin
      if (start) begin
        active_q <= 1'b1;
        cs_n_q   <= 1'b0;
        mosi_q   <= frame[FRAME_BITS-1];
        tx_q     <= {frame[FRAME_BITS-2:0], 1'b0};
        div_q    <= '0;
        bit_q    <= '0;
        sclk_q   <= 1'b0;
      end
    end else if (!tick) begin
      div_q <= div_q + 8'd1;
    end else begin
      div_q <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], spi_miso};
      end else begin
        sclk_q <= 1'b0;
        if (bit_q == LAST_BIT) begin
          active_q <= 1'b0;
          cs_n_q   <= 1'b1;
          mosi_q   <= 1'b0;
        end else begin
          bit_q  <= bit_q + 5'd1;
          mosi_q <= tx_q[FRAME_BITS-1];
          tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: services the CPU byte bus from an external SPI SRAM, one
// complete SPI frame per access. Optional single-entry read cache enabled
// by defining SPI_MEM_CACHE_EN.
`timescale 1ns/1ps
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic     clk,
  input  logic     rst,
  spi_mem_if.slave bus,
  output logic     spi_cs_n,
  output logic     spi_clk,
  output logic     spi_mosi,
  input  logic     spi_miso,
  output state_e   dbg_state
);

  state_e                state_q, state_d;
  logic                  accept;
  logic                  cache_hit;
  logic                  start;
  logic                  done_c;
  logic                  frame_done;
  logic                  req_write_q;
  logic [7:0]            rdata_q;
  logic [7:0]            rx_byte;
  logic [7:0]            hit_data;
  logic [FRAME_BITS-1:0] frame;

  // Write wins when both strobes are high.
  assign accept = (state_q == IDLE) && (bus.bus_read || bus.bus_write);
  // The shifter captures the frame at acceptance, which also latches the
  // address and write data for the SPI side.
  assign frame  = build_frame(bus.bus_write, bus.bus_address_in, bus.bus_wdata);

`ifdef SPI_MEM_CACHE_EN
  logic        cache_valid_q;
  logic [15:0] cache_tag_q;
  logic [7:0]  cache_data_q;
  logic [15:0] req_addr_q;
  logic [7:0]  req_wdata_q;

  assign cache_hit = cache_valid_q && !bus.bus_write &&
                     (cache_tag_q == bus.bus_address_in);
  assign hit_data  = cache_data_q;

  // Cache entry: filled by read misses and by writes (write-allocate) when
  // their SPI frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
    end else begin
      if (accept) begin
        req_addr_q  <= bus.bus_address_in;
        req_wdata_q <= bus.bus_wdata;
      end
      if ((state_q == SHIFT) && frame_done) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= req_addr_q;
        cache_data_q  <= req_write_q ? req_wdata_q : rx_byte;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = 8'h00;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: hits skip straight to DONE, misses wait for the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = cache_hit ? DONE : SHIFT;
      SHIFT:   if (frame_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: frame start on an uncached acceptance, done pulse in DONE.
  always_comb begin
    start  = accept && !cache_hit;
    done_c = (state_q == DONE);
  end

  // Request kind and read data; bus_rdata only changes when a read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_write_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      if (accept) req_write_q <= bus.bus_write;
      if (accept && cache_hit) rdata_q <= hit_data;
      else if ((state_q == SHIFT) && frame_done && !req_write_q) rdata_q <= rx_byte;
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_done  = done_c;
  assign dbg_state     = state_q;

  spi_mem_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame      (frame),
    .frame_done (frame_done),
    .rx_byte    (rx_byte),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: two bridges (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural 23K256-style SPI SRAM. Expected values come from a memory
// model plus a "last accessed address" view of the optional cache
// (SPI_MEM_CACHE_EN).
`timescale 1ns/1ps
module tb_spi_mem_bridge;
  import spi_mem_pkg::*;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;
`ifdef SPI_MEM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_if bus0();
  spi_mem_if bus1();
  logic [1:0] cs_n, sclk, mosi, miso;
  state_e st0, st1;

  spi_mem_bridge #(.CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .spi_cs_n(cs_n[0]), .spi_clk(sclk[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .dbg_state(st0));

  spi_mem_bridge #(.CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .spi_cs_n(cs_n[1]), .spi_clk(sclk[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .dbg_state(st1));

  // Power-up SRAM contents: addr 0x0007 -> 0x77, 0x0001 -> 0x11, ...
  function automatic logic [7:0] pat(input logic [15:0] a);
    return {a[3:0], a[3:0]} ^ a[15:8];
  endfunction

  // ---------------- SPI SRAM models (sampled on negedge clk) ----------------
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic p_cs = 1'b1, p_clk = 1'b0, so = 1'b0, is_rd = 1'b0;
    logic [31:0] sr = '0, last_frame = '0;
    logic [7:0] out_byte = '0;
    int bits = 0, frames = 0, rises = 0;
    time fall_t = 0;
    logic [7:0] mem [int];
    assign miso[g] = so;
    always @(negedge clk) begin
      if (!cs_n[g] && p_cs) begin
        bits = 0; sr = '0; fall_t = $time;
      end
      if (sclk[g] && !p_clk) begin
        rises++;
        if (!cs_n[g]) begin
          sr = {sr[30:0], mosi[g]};
          bits++;
          if (bits == 24) begin
            is_rd = (sr[23:16] == 8'h03);
            out_byte = mem.exists(int'(sr[15:0])) ? mem[int'(sr[15:0])] : pat(sr[15:0]);
          end
          if (bits == 32) begin
            frames++;
            last_frame = sr;
            if (sr[31:24] == 8'h02) mem[int'(sr[23:8])] = sr[7:0];
          end
        end
      end
      if (!sclk[g] && p_clk && !cs_n[g] && is_rd && bits >= 24 && bits < 32)
        so = out_byte[3'(31 - bits)];
      p_cs = cs_n[g];
      p_clk = sclk[g];
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model of the SRAM behind dut0 and of what dut0 returns.
  logic [7:0] ref_mem [int];
  int last_addr = -1;
  logic [7:0] exp_rd0 = 8'h00;

  task automatic model_step(input bit rd, input bit wr, input logic [15:0] a,
                            input logic [7:0] w, output bit hit, output logic [7:0] exp_r);
    hit = CACHE && rd && !wr && (last_addr == int'(a));
    if (wr) ref_mem[int'(a)] = w;
    else exp_rd0 = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    last_addr = int'(a);
    exp_r = exp_rd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [7:0] w);
    if (d == 0) begin
      bus0.bus_read = rd; bus0.bus_write = wr; bus0.bus_address_in = a; bus0.bus_wdata = w;
    end else begin
      bus1.bus_read = rd; bus1.bus_write = wr; bus1.bus_address_in = a; bus1.bus_wdata = w;
    end
  endtask

  function automatic logic get_done(input int d);
    return (d == 0) ? bus0.bus_done : bus1.bus_done;
  endfunction

  function automatic logic [7:0] get_rdata(input int d);
    return (d == 0) ? bus0.bus_rdata : bus1.bus_rdata;
  endfunction

  // Issue one access (called away from clock edges); lat is the cycle index
  // after the acceptance edge in which bus_done is seen.
  task automatic access(input int d, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [7:0] w, output int lat, output logic [7:0] rdo,
                        output int cs_low, output time done_t);
    drive(d, rd, wr, a, w);
    @(posedge clk);
    lat = 0;
    cs_low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (cs_n[d] == 1'b0) cs_low++;
    end while (!get_done(d) && lat < 400);
    chk("done_seen", get_done(d), 1'b1);
    rdo = get_rdata(d);
    done_t = $time;
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, a, w);
    @(negedge clk);
    chk("done_once", get_done(d), 1'b0);
    #1;
  endtask

  // Access on dut0 with every expectation taken from the reference model.
  task automatic do_dut0(input string nm, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] w);
    bit hit;
    logic [7:0] er, got;
    int r0, f0, lat, csl;
    time dt;
    model_step(rd, wr, a, w, hit, er);
    r0 = g_slv[0].rises;
    f0 = g_slv[0].frames;
    access(0, rd, wr, a, w, lat, got, csl, dt);
    chk({nm, "_lat"}, lat, hit ? 1 : 64 * DIV0 + 1);
    chk({nm, "_cs_low"}, csl, hit ? 0 : 64 * DIV0);
    chk({nm, "_rdata"}, got, er);
    chk({nm, "_frames"}, g_slv[0].frames - f0, hit ? 0 : 1);
    chk({nm, "_sclk_rises"}, g_slv[0].rises - r0, hit ? 0 : 32);
    if (!hit)
      chk({nm, "_frame"}, g_slv[0].last_frame, {(wr ? 8'h02 : 8'h03), a, (wr ? w : 8'h00)});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [31:0] exp_frame;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    logic [7:0] er, got, got2;
    int lat, lat2, csl, csl2, f0, n;
    time dt, dt2;
    logic done_during_rst;

    vt[0] = '{1'b1, 1'b0, 16'h0007, 8'h00, 32'h03000700, 8'h77, 129};
    vt[1] = '{1'b0, 1'b1, 16'hFF00, 8'hA5, 32'h02FF00A5, 8'h77, 129};
    vt[2] = '{1'b1, 1'b1, 16'h1234, 8'h5A, 32'h0212345A, 8'h77, 129};
    vt[3] = '{1'b1, 1'b0, 16'hFF00, 8'h00, 32'h03FF0000, 8'hA5, 129};
    vt[4] = '{1'b1, 1'b0, 16'h0007, 8'h00, 32'h03000700, 8'h77, 129};

    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_cs_n%0d", d), cs_n[d], 1'b1);
      chk($sformatf("rst_sclk%0d", d), sclk[d], 1'b0);
      chk($sformatf("rst_mosi%0d", d), mosi[d], 1'b0);
      chk($sformatf("rst_done%0d", d), get_done(d), 1'b0);
      chk($sformatf("rst_rdata%0d", d), get_rdata(d), 8'h00);
    end
    chk("rst_state0", 32'(st0), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Table: read, write, write-wins, read-back, repeat read.
    for (int i = 0; i < 5; i++) begin
      model_step(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, hit, er);
      f0 = g_slv[0].frames;
      access(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, lat, got, csl, dt);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_cs_low", i), csl, 128);
      chk($sformatf("vec%0d_frame", i), g_slv[0].last_frame, vt[i].exp_frame);
      chk($sformatf("vec%0d_frames", i), g_slv[0].frames - f0, 1);
      chk($sformatf("vec%0d_rdata", i), got, vt[i].exp_rdata);
    end
    chk("slave_mem_ff00", g_slv[0].mem[32'hFF00], 8'hA5);

    // Repeated read, write-allocate, read-back.
    do_dut0("c_rd1", 1'b1, 1'b0, 16'h0010, 8'h00);
    do_dut0("c_rd2", 1'b1, 1'b0, 16'h0010, 8'h00);
    do_dut0("c_wr", 1'b0, 1'b1, 16'h0010, 8'h3C);
    do_dut0("c_rd3", 1'b1, 1'b0, 16'h0010, 8'h00);

    // Reset in the middle of a read frame.
    f0 = g_slv[0].frames;
    drive(0, 1'b1, 1'b0, 16'h0042, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1;
    n = 0;
    while (g_slv[0].bits < 15 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reached_bit15", 32'(g_slv[0].bits), 15);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0042, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs_n", cs_n[0], 1'b1);
    chk("abort_sclk", sclk[0], 1'b0);
    chk("abort_state", 32'(st0), 32'(IDLE));
    done_during_rst = get_done(0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      done_during_rst = done_during_rst | get_done(0);
    end
    chk("abort_no_done", done_during_rst, 1'b0);
    chk("abort_no_frame", g_slv[0].frames - f0, 0);
    chk("abort_rdata_rst", get_rdata(0), 8'h00);
    last_addr = -1;
    exp_rd0 = 8'h00;
    #1;
    do_dut0("post_rst_rd", 1'b1, 1'b0, 16'h0010, 8'h00);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 16; i++) begin
      int op;
      logic [15:0] a;
      logic [7:0] w;
      op = $urandom_range(0, 2);
      a = 16'h0100 + 16'($urandom_range(0, 3));
      w = 8'($urandom);
      do_dut0($sformatf("rnd%0d", i), op != 1, op != 0, a, w);
    end

    // CLK_DIV=1 back-to-back reads.
    f0 = g_slv[1].frames;
    access(1, 1'b1, 1'b0, 16'h0000, 8'h00, lat, got, csl, dt);
    access(1, 1'b1, 1'b0, 16'h0001, 8'h00, lat2, got2, csl2, dt2);
    chk("b2b_lat1", lat, 65);
    chk("b2b_lat2", lat2, 65);
    chk("b2b_cs_low1", csl, 64);
    chk("b2b_cs_low2", csl2, 64);
    chk("b2b_rdata1", got, pat(16'h0000));
    chk("b2b_rdata2", got2, pat(16'h0001));
    chk("b2b_frames", g_slv[1].frames - f0, 2);
    chk("b2b_frame2", g_slv[1].last_frame, 32'h03000100);
    chk("b2b_gap", 32'(g_slv[1].fall_t - dt), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
